// File: rtl/spi_word_slave_if.sv
// spi_word_slave_if: host-side word interface of spi_word_slave.
//   tx_data/tx_valid/tx_ready : buffered transmit word, valid/ready handshake
//   rx_data/rx_valid          : last received word and its one-cycle strobe
//   frame_active              : synchronised SEL asserted
//   frame_err                 : one-cycle strobe, frame ended mid-word
//   tx_underrun               : one-cycle strobe, fallback word loaded at a word boundary
// Modports: master = host logic, slave = spi_word_slave.
interface spi_word_slave_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_active;
  logic             frame_err;
  logic             tx_underrun;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, frame_active, frame_err, tx_underrun
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, frame_active, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_word_slave.sv
// spi_word_slave: oversampling SPI slave for the Raspberry Pi bus, WIDTH-bit
// words MSB first, SPI mode MODE (CPOL = MODE[1], CPHA = MODE[0]), multi-word frames.
// Ports:
//   ico_clk, ico_rst_n : system clock (>= 8x pi_clk), async active-low reset
//   pi_clk, SEL, MOSI  : asynchronous SPI inputs (SEL active low)
//   MISO               : serial data out, always driven
//   host               : spi_word_slave_if.slave (tx handshake, rx strobe, status)
// Build option: define SPI_ECHO_EN to make the fallback transmit word the last
// received word (loopback); otherwise the fallback word is TX_IDLE.
module spi_word_slave #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      MODE    = 0,
  parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
  input  logic             ico_clk,
  input  logic             ico_rst_n,
  input  logic             pi_clk,
  input  logic             SEL,
  input  logic             MOSI,
  output logic             MISO,
  spi_word_slave_if.slave  host
);
  localparam int unsigned CW     = $clog2(WIDTH) + 1;
  localparam logic [1:0]  MODE_B = 2'(MODE);
  localparam logic        CPOL   = MODE_B[1];
  localparam logic        CPHA   = MODE_B[0];

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
  state_t state_q, state_nxt;

  logic [2:0]       pclk_q;
  logic [1:0]       sel_q, mosi_q, sync_ok_q;
  logic             sel_armed_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-2:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q, tx_shift_q, hold_q;
  logic             hold_empty_q, rx_valid_q, frame_active_q, frame_err_q;
  logic             tx_underrun_q, reload_pend_q;

  logic             sel_s, mosi_s, rise_c, fall_c, sample_c, shedge_c;
  logic             load_c, active_c, end_c;
  logic             samp_act_c, word_done_c, reload_c, txshift_c, fetch_c, cap_c, underrun_c;
  logic [CW-1:0]    bit_cnt_upd_c;
  logic [WIDTH-1:0] rx_word_c, fallback_c, tx_next_c;

  // Input synchronisers; sync_ok/sel_armed make a frame cut by reset wait for SEL high then low.
  always_ff @(posedge ico_clk or negedge ico_rst_n) begin
    if (!ico_rst_n) begin
      pclk_q      <= {3{CPOL}};
      sel_q       <= 2'b11;
      mosi_q      <= 2'b00;
      sync_ok_q   <= 2'b00;
      sel_armed_q <= 1'b0;
    end else begin
      pclk_q    <= {pclk_q[1:0], pi_clk};
      sel_q     <= {sel_q[0], SEL};
      mosi_q    <= {mosi_q[0], MOSI};
      sync_ok_q <= {sync_ok_q[0], 1'b1};
      if (sync_ok_q[1] && sel_s) sel_armed_q <= 1'b1;
    end
  end

  // Edge roles from the synchronised clock.
  always_comb begin
    sel_s    = sel_q[1];
    mosi_s   = mosi_q[1];
    rise_c   = pclk_q[1] & ~pclk_q[2];
    fall_c   = ~pclk_q[1] & pclk_q[2];
    sample_c = (CPOL ^ CPHA) ? fall_c : rise_c;
    shedge_c = (CPOL ^ CPHA) ? rise_c : fall_c;
  end

  // FSM state register.
  always_ff @(posedge ico_clk or negedge ico_rst_n) begin
    if (!ico_rst_n) state_q <= IDLE;
    else            state_q <= state_nxt;
  end

  // FSM next state; SEL high always returns to IDLE.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (sel_armed_q && !sel_s) state_nxt = LOAD;
      LOAD:    state_nxt = sel_s ? IDLE : SHIFT;
      SHIFT:   if (sel_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    load_c   = 1'b0;
    active_c = 1'b0;
    end_c    = 1'b0;
    unique case (state_q)
      LOAD: begin
        load_c = ~sel_s;
        end_c  = sel_s;
      end
      SHIFT: begin
        active_c = 1'b1;
        end_c    = sel_s;
      end
      default: ;
    endcase
  end

  // Bit accounting, tx word selection and holding-register bypass.
  always_comb begin
    reload_c      = 1'b0;
    txshift_c     = 1'b0;
    bit_cnt_upd_c = bit_cnt_q;
    rx_word_c     = {rx_shift_q, mosi_s};
    samp_act_c    = active_c && sample_c;
    word_done_c   = samp_act_c && (bit_cnt_q == CW'(WIDTH - 1));
    if (word_done_c)     bit_cnt_upd_c = '0;
    else if (samp_act_c) bit_cnt_upd_c = bit_cnt_q + CW'(1);
    // A reload is pointless (and would drain the holding register) once SEL has risen.
    if (CPHA) begin
      reload_c  = word_done_c && !sel_s;
      txshift_c = active_c && shedge_c && (bit_cnt_q != '0);
    end else begin
      reload_c  = active_c && shedge_c && reload_pend_q && !sel_s;
      txshift_c = active_c && shedge_c && !reload_pend_q;
    end
    fetch_c = load_c || reload_c;
    cap_c   = host.tx_valid && hold_empty_q;
`ifdef SPI_ECHO_EN
    // CPHA=1 reloads in the same cycle the word completes, before rx_data updates.
    fallback_c = word_done_c ? rx_word_c : rx_data_q;
`else
    fallback_c = TX_IDLE;
`endif
    if (!hold_empty_q) tx_next_c = hold_q;
    else if (cap_c)    tx_next_c = host.tx_data;
    else               tx_next_c = fallback_c;
    underrun_c = reload_c && hold_empty_q && !cap_c;
  end

  // Datapath and registered host outputs.
  always_ff @(posedge ico_clk or negedge ico_rst_n) begin
    if (!ico_rst_n) begin
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_shift_q     <= TX_IDLE;
      hold_q         <= '0;
      hold_empty_q   <= 1'b1;
      frame_active_q <= 1'b0;
      frame_err_q    <= 1'b0;
      tx_underrun_q  <= 1'b0;
      reload_pend_q  <= 1'b0;
    end else begin
      rx_valid_q     <= word_done_c;
      frame_err_q    <= end_c && (bit_cnt_upd_c != '0);
      tx_underrun_q  <= underrun_c;
      frame_active_q <= (state_nxt != IDLE);
      bit_cnt_q      <= (state_q == IDLE || end_c) ? '0 : bit_cnt_upd_c;
      if (samp_act_c)  rx_shift_q <= rx_word_c[WIDTH-2:0];
      if (word_done_c) rx_data_q  <= rx_word_c;
      if (state_q == IDLE)             reload_pend_q <= 1'b0;
      else if (word_done_c)            reload_pend_q <= ~CPHA;
      else if (active_c && shedge_c)   reload_pend_q <= 1'b0;
      if (fetch_c)        tx_shift_q <= tx_next_c;
      else if (txshift_c) tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
      if (cap_c) hold_q <= host.tx_data;
      if (fetch_c)    hold_empty_q <= 1'b1;
      else if (cap_c) hold_empty_q <= 1'b0;
    end
  end

  assign MISO              = tx_shift_q[WIDTH-1];
  assign host.tx_ready     = hold_empty_q;
  assign host.rx_data      = rx_data_q;
  assign host.rx_valid     = rx_valid_q;
  assign host.frame_active = frame_active_q;
  assign host.frame_err    = frame_err_q;
  assign host.tx_underrun  = tx_underrun_q;
endmodule
